// File: rtl/soc_system_sysid_pkg.sv
// Shared definitions for the system-ID checker: FSM states, slave word addresses
// and the default expected ID/timestamp values.
package soc_system_sysid_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ID_REQ  = 3'd1,
        ID_WAIT = 3'd2,
        TS_REQ  = 3'd3,
        TS_WAIT = 3'd4,
        DONE    = 3'd5
    } sysid_state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    // Also consumed by the sysid slave generator; keep both sides in step.
    localparam logic [31:0] SYSID_DEFAULT_ID        = 32'hACD5_1302;
    localparam logic [31:0] SYSID_DEFAULT_TIMESTAMP = 32'h58D2_05E7;

    function automatic logic sysid_is_active(sysid_state_e s);
        return (s == ID_REQ) || (s == ID_WAIT) || (s == TS_REQ) || (s == TS_WAIT);
    endfunction

endpackage

// File: rtl/soc_system_sysid_if.sv
// Avalon-MM read-only link between the sysid checker (master) and the sysid slave.
//
// Handshake: a request is read=1; it is accepted on a rising edge where
// waitrequest=0, and address/read stay unchanged until then. The response is
// the single cycle with readdatavalid=1; readdata is meaningful only in that cycle.
interface soc_system_sysid_if;
    logic        address;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport master (
        output address,
        output read,
        input  waitrequest,
        input  readdata,
        input  readdatavalid
    );

    modport slave (
        input  address,
        input  read,
        output waitrequest,
        output readdata,
        output readdatavalid
    );
endinterface

// File: rtl/soc_system_sysid_watchdog.sv
// Per-transaction cycle counter for the sysid checker; used only when
// SYSID_CHECK_WATCHDOG_EN is defined.
module soc_system_sysid_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != W'(LIMIT))) begin
            count <= count + 1'b1;
        end
    end

    // Fires in the cycle whose edge would bring the count to LIMIT, so a state
    // lasts exactly LIMIT cycles before the FSM leaves it.
    assign expired = enable && (count == W'(LIMIT - 1));

endmodule

// File: rtl/soc_system_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words and checks
// them against build-time values. Optional watchdog: SYSID_CHECK_WATCHDOG_EN.
module soc_system_sysid_checker
    import soc_system_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TIMESTAMP,
    parameter int          TIMEOUT_CYCLES     = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    soc_system_sysid_if.master  bus,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                id_ok,
    output logic                ts_ok,
    output logic                timeout,
    output logic [31:0]         id_value,
    output logic [31:0]         ts_value,
    output sysid_state_e        state_dbg
);

    sysid_state_e state, next_state;
    logic         wd_expired;
    logic         wd_fire;
    logic         start_accept;

`ifdef SYSID_CHECK_WATCHDOG_EN
    logic wd_clear;
    logic wd_enable;

    assign wd_clear  = (next_state != state);
    assign wd_enable = sysid_is_active(state);

    soc_system_sysid_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );
`else
    logic unused_timeout_cfg;

    assign wd_expired         = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    assign start_accept = start && ((state == IDLE) || (state == DONE));
    assign state_dbg    = state;

    // A response or acceptance in the expiry cycle wins over the watchdog.
    always_comb begin
        next_state = state;
        wd_fire    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) next_state = ID_REQ;
            end
            ID_REQ: begin
                if (!bus.waitrequest) next_state = ID_WAIT;
                else if (wd_expired) begin
                    next_state = DONE;
                    wd_fire    = 1'b1;
                end
            end
            ID_WAIT: begin
                if (bus.readdatavalid) next_state = TS_REQ;
                else if (wd_expired) begin
                    next_state = DONE;
                    wd_fire    = 1'b1;
                end
            end
            TS_REQ: begin
                if (!bus.waitrequest) next_state = TS_WAIT;
                else if (wd_expired) begin
                    next_state = DONE;
                    wd_fire    = 1'b1;
                end
            end
            TS_WAIT: begin
                if (bus.readdatavalid) next_state = DONE;
                else if (wd_expired) begin
                    next_state = DONE;
                    wd_fire    = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Bus outputs are decoded from next_state so they are registered yet line
    // up with the state they belong to.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.read    <= 1'b0;
            bus.address <= SYSID_ADDR_ID;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            bus.read    <= (next_state == ID_REQ) || (next_state == TS_REQ);
            bus.address <= ((next_state == TS_REQ) || (next_state == TS_WAIT))
                           ? SYSID_ADDR_TS : SYSID_ADDR_ID;
            busy        <= sysid_is_active(next_state);
            done        <= (next_state == DONE);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pass     <= 1'b0;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
        end else begin
            if (start_accept) begin
                pass    <= 1'b0;
                id_ok   <= 1'b0;
                ts_ok   <= 1'b0;
                timeout <= 1'b0;
            end
            if ((state == ID_WAIT) && bus.readdatavalid) begin
                id_value <= bus.readdata;
                id_ok    <= (bus.readdata == EXPECTED_ID);
            end
            if ((state == TS_WAIT) && bus.readdatavalid) begin
                ts_value <= bus.readdata;
                ts_ok    <= (bus.readdata == EXPECTED_TIMESTAMP);
                pass     <= id_ok && (bus.readdata == EXPECTED_TIMESTAMP);
            end
            if (wd_fire) begin
                timeout <= 1'b1;
                pass    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// Directed bench for soc_system_sysid_checker: a task-driven Avalon slave with
// configurable stalls/delays, and hand-computed expected results.
module tb_soc_system_sysid_checker;
    import soc_system_sysid_pkg::*;

    localparam logic [31:0] GOOD_ID    = 32'hACD5_1302;
    localparam logic [31:0] GOOD_TS    = 32'h58D2_05E7;
    localparam int          CYCLE_LIMIT = 40;

    logic         clk;
    logic         rst;
    logic         start;
    logic         busy;
    logic         done;
    logic         pass;
    logic         id_ok;
    logic         ts_ok;
    logic         timeout;
    logic [31:0]  id_value;
    logic [31:0]  ts_value;
    sysid_state_e state_dbg;

    int n_cmp;
    int n_err;
    int lat;

    soc_system_sysid_if bus();

    soc_system_sysid_checker #(
        .EXPECTED_ID        (32'hACD5_1302),
        .EXPECTED_TIMESTAMP (32'h58D2_05E7),
        .TIMEOUT_CYCLES     (8)
    ) dut (
        .clock     (clk),
        .reset     (rst),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .id_ok     (id_ok),
        .ts_ok     (ts_ok),
        .timeout   (timeout),
        .id_value  (id_value),
        .ts_value  (ts_value),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL sim_time_limit: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_idle_outputs();
        check("rst_read",     bus.read, 1'b0);
        check("rst_address",  bus.address, 1'b0);
        check("rst_busy",     busy, 1'b0);
        check("rst_done",     done, 1'b0);
        check("rst_pass",     pass, 1'b0);
        check("rst_id_ok",    id_ok, 1'b0);
        check("rst_ts_ok",    ts_ok, 1'b0);
        check("rst_timeout",  timeout, 1'b0);
        check("rst_id_value", id_value, 32'h0);
        check("rst_ts_value", ts_value, 32'h0);
        check("rst_state",    32'(state_dbg), 32'(IDLE));
    endtask

    // Pulses start, then plays the slave one cycle at a time. lat is the number
    // of rising edges from the start edge until done is seen (-1 if never).
    task automatic run_check(input logic [31:0] id_w, input logic [31:0] ts_w,
                             input int n_wait, input int n_delay,
                             input bit stray, input bit poke_start, input bit hang,
                             input int stop_at, output int lat_o);
        int   cyc;
        int   stall_cnt;
        int   dly_cnt;
        bit   pending;
        bit   in_stall;
        bit   stray_done;
        logic hold_addr;
        logic pend_addr;
        stall_cnt  = 0;
        dly_cnt    = 0;
        pending    = 1'b0;
        in_stall   = 1'b0;
        stray_done = 1'b0;
        hold_addr  = 1'b0;
        pend_addr  = 1'b0;
        lat_o      = -1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (cyc <= CYCLE_LIMIT) begin
            if (done) begin
                lat_o = cyc;
                break;
            end
            if (cyc == stop_at) break;
            if (cyc == 1) begin
                check("busy_rise", busy, 1'b1);
                check("read_rise", bus.read, 1'b1);
                check("clear_on_start", {29'd0, pass, id_ok, timeout}, 32'h0);
            end
            bus.readdatavalid = 1'b0;
            bus.waitrequest   = 1'b0;
            start             = poke_start && (cyc == 2);
            if (pending) begin
                check("one_outstanding", bus.read, 1'b0);
                if (dly_cnt == 0) begin
                    bus.readdatavalid = 1'b1;
                    bus.readdata      = pend_addr ? ts_w : id_w;
                    pending           = 1'b0;
                end else begin
                    dly_cnt--;
                end
            end else if (bus.read || in_stall) begin
                if (in_stall) begin
                    check("stall_read", bus.read, 1'b1);
                    check("stall_addr", bus.address, hold_addr);
                end
                if (stray && !stray_done && (bus.address == 1'b0)) begin
                    bus.readdatavalid = 1'b1;
                    bus.readdata      = 32'hDEAD_BEEF;
                    stray_done        = 1'b1;
                end
                if (stall_cnt < n_wait) begin
                    if (!in_stall) hold_addr = bus.address;
                    bus.waitrequest = 1'b1;
                    stall_cnt++;
                    in_stall = 1'b1;
                end else begin
                    stall_cnt = 0;
                    in_stall  = 1'b0;
                    pending   = !hang;
                    pend_addr = bus.address;
                    dly_cnt   = n_delay;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.readdatavalid = 1'b0;
        bus.waitrequest   = 1'b0;
        start             = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        bus.waitrequest   = 1'b0;
        bus.readdata      = 32'h0;
        bus.readdatavalid = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs();
        rst = 1'b0;

        // nominal, zero-wait slave
        run_check(GOOD_ID, GOOD_TS, 0, 0, 1'b0, 1'b0, 1'b0, 0, lat);
        check("nom_latency",  lat, 32'd5);
        check("nom_pass",     pass, 1'b1);
        check("nom_id_ok",    id_ok, 1'b1);
        check("nom_ts_ok",    ts_ok, 1'b1);
        check("nom_busy",     busy, 1'b0);
        check("nom_timeout",  timeout, 1'b0);
        check("nom_id_value", id_value, 32'hACD5_1302);
        check("nom_ts_value", ts_value, 32'h58D2_05E7);

        // ID mismatch
        run_check(32'hACD5_1303, GOOD_TS, 0, 0, 1'b0, 1'b0, 1'b0, 0, lat);
        check("idbad_latency",  lat, 32'd5);
        check("idbad_done",     done, 1'b1);
        check("idbad_id_ok",    id_ok, 1'b0);
        check("idbad_ts_ok",    ts_ok, 1'b1);
        check("idbad_pass",     pass, 1'b0);
        check("idbad_id_value", id_value, 32'hACD5_1303);

        // timestamp mismatch
        run_check(GOOD_ID, 32'h58D2_05E6, 0, 0, 1'b0, 1'b0, 1'b0, 0, lat);
        check("tsbad_id_ok",    id_ok, 1'b1);
        check("tsbad_ts_ok",    ts_ok, 1'b0);
        check("tsbad_pass",     pass, 1'b0);
        check("tsbad_ts_value", ts_value, 32'h58D2_05E6);

        // 3 waitrequest cycles per read, responses 2 cycles late
        run_check(GOOD_ID, GOOD_TS, 3, 2, 1'b0, 1'b0, 1'b0, 0, lat);
        check("stall_latency", lat, 32'd15);
        check("stall_pass",    pass, 1'b1);
        check("stall_done",    done, 1'b1);

        // start while busy plus a stray response during ID_REQ
        run_check(GOOD_ID, GOOD_TS, 0, 0, 1'b1, 1'b1, 1'b0, 0, lat);
        check("stray_latency",  lat, 32'd5);
        check("stray_pass",     pass, 1'b1);
        check("stray_id_value", id_value, 32'hACD5_1302);
        check("stray_ts_value", ts_value, 32'h58D2_05E7);

        // slave accepts the ID read but never responds
        run_check(GOOD_ID, GOOD_TS, 0, 0, 1'b0, 1'b0, 1'b1, 0, lat);
`ifdef SYSID_CHECK_WATCHDOG_EN
        check("wd_latency", lat, 32'd10);
        check("wd_timeout", timeout, 1'b1);
        check("wd_pass",    pass, 1'b0);
        check("wd_done",    done, 1'b1);
        check("wd_busy",    busy, 1'b0);
        bus.readdatavalid = 1'b1;
        bus.readdata      = 32'h1234_5678;
        @(negedge clk);
        bus.readdatavalid = 1'b0;
        @(negedge clk);
        check("wd_late_id_value", id_value, 32'hACD5_1302);
        check("wd_late_state",    32'(state_dbg), 32'(DONE));
        check("wd_late_timeout",  timeout, 1'b1);
`else
        check("hang_latency", lat, 32'hFFFF_FFFF);
        check("hang_busy",    busy, 1'b1);
        check("hang_done",    done, 1'b0);
        check("hang_timeout", timeout, 1'b0);
        check("hang_state",   32'(state_dbg), 32'(ID_WAIT));
        #2 rst = 1'b1;
        #1 check("hang_rst_state", 32'(state_dbg), 32'(IDLE));
        check("hang_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
`endif

        // reset asserted in TS_WAIT, between clock edges
        run_check(GOOD_ID, GOOD_TS, 0, 0, 1'b0, 1'b0, 1'b0, 4, lat);
        check("pre_rst_state", 32'(state_dbg), 32'(TS_WAIT));
        #2 rst = 1'b1;
        #1 check_idle_outputs();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.readdatavalid = 1'b1;
        bus.readdata      = GOOD_TS;
        @(negedge clk);
        bus.readdatavalid = 1'b0;
        check("late_rsp_ts_value", ts_value, 32'h0);
        check("late_rsp_state",    32'(state_dbg), 32'(IDLE));
        check("late_rsp_done",     done, 1'b0);

        run_check(GOOD_ID, GOOD_TS, 0, 0, 1'b0, 1'b0, 1'b0, 0, lat);
        check("post_rst_latency", lat, 32'd5);
        check("post_rst_pass",    pass, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
